// File: rtl/logic_stream_reducer.sv
// rtl/logic_stream_reducer.sv - bitwise gate reduction of a beat stream, one result per packet
module logic_stream_reducer #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic                                 in_last,
    input  logic [2:0]                           op,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0]       out_count,
    output logic                                 out_err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;

    logic             beat;
    logic             invert;
    logic [CNT_W-1:0] count_inc;

    // Illegal codes 110/111 share the AND path with 000 and 011.
    function automatic logic [WIDTH-1:0] base_gate(input logic [2:0] sel,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b001, 3'b100: r = a | b;
            3'b010, 3'b101: r = a ^ b;
            default:        r = a & b;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid && in_ready;
    assign invert    = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
    assign count_inc = count_q + ONE_CNT;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    op_d    = op;
                    acc_d   = in_data;
                    count_d = ONE_CNT;
                    err_d   = op[2] & op[1];
                    state_d = (in_last || (MAX_BEATS == 1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d   = base_gate(op_q, acc_q, in_data);
                    count_d = count_inc;
                    if (in_last) begin
                        state_d = HOLD;
                    end else if (count_inc == MAX_CNT) begin
                        // Packet overran MAX_BEATS: close it out and flag it.
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = out_valid ? (invert ? ~acc_q : acc_q) : '0;
    assign out_count = out_valid ? count_q : '0;
    assign out_err   = out_valid ? err_q : 1'b0;

endmodule
